ifq_buffer: RTL and testbench

Instruction fetch queue between the fetch stage and the decode stage of the 5-stage MIPS pipeline. It captures each fetched word with its PC+4 and holds up to `DEPTH` entries. It presents the oldest entry to decode in show-ahead form. Back-pressure from decode reaches fetch only when the queue is full, and a decode-side flush (branch/jump redirect) discards every buffered word.

---
 rtl/ifq_buffer.sv | 88 ++++++++
 tb/tb_ifq_buffer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ifq_buffer.sv
// Instruction fetch queue: DEPTH-entry circular buffer of {Instr, PC4} between fetch and decode.
// Optional same-cycle bypass of an empty queue is enabled by defining IFQ_BYPASS_EN.
module ifq_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   Instr,
    input  logic [31:0]   PC4,
    input  logic          FetchValid,
    input  logic          StallD,
    input  logic          FlushD,
    output logic          StallF,
    output logic [31:0]   InstrD,
    output logic [31:0]   PC4D,
    output logic          ValidD,
    output logic [AW:0]   Count
);
    // Handshakes: a fetch word transfers when FetchValid=1 and StallF=0 (flush drops it);
    // a head word transfers to decode when ValidD=1 and StallD=0 (flush discards it).

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [63:0]   head;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full   = (cnt == DEPTH_CNT);
    assign empty  = (cnt == '0);
    assign StallF = full;
    assign Count  = cnt;
    assign head   = mem[rp];

    always_comb begin
        InstrD = '0;
        PC4D   = '0;
        ValidD = 1'b0;
        push   = FetchValid & ~full & ~FlushD;
        pop    = ~empty & ~StallD & ~FlushD;
        if (!empty) begin
            InstrD = head[63:32];
            PC4D   = head[31:0];
            ValidD = 1'b1;
        end
`ifdef IFQ_BYPASS_EN
        else if (FetchValid && !FlushD) begin
            // Empty queue: hand the incoming word straight to decode; store it only if decode stalls.
            InstrD = Instr;
            PC4D   = PC4;
            ValidD = 1'b1;
            if (!StallD) begin
                push = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset || FlushD) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset: every entry is gated by cnt before it is ever presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= {Instr, PC4};
        end
    end

endmodule

// File: tb/tb_ifq_buffer.sv
// Bench for ifq_buffer: directed and random steps checked each cycle against a queue model.
module tb_ifq_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   Instr;
    logic [31:0]   PC4;
    logic          FetchValid;
    logic          StallD;
    logic          FlushD;
    logic          StallF;
    logic [31:0]   InstrD;
    logic [31:0]   PC4D;
    logic          ValidD;
    logic [AW:0]   Count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    logic [63:0] exp_q[$];

    ifq_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .PC4(PC4),
        .FetchValid(FetchValid), .StallD(StallD), .FlushD(FlushD),
        .StallF(StallF), .InstrD(InstrD), .PC4D(PC4D), .ValidD(ValidD), .Count(Count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected outputs follow from the queue contents (and the bypass rule when enabled).
    task automatic check_outputs();
        logic [31:0] e_instr = 32'h0;
        logic [31:0] e_pc4   = 32'h0;
        logic [31:0] e_valid = 32'h0;
        if (exp_q.size() > 0) begin
            e_instr = exp_q[0][63:32];
            e_pc4   = exp_q[0][31:0];
            e_valid = 32'h1;
        end
`ifdef IFQ_BYPASS_EN
        else if (FetchValid && !FlushD) begin
            e_instr = Instr;
            e_pc4   = PC4;
            e_valid = 32'h1;
        end
`endif
        check("valid_d", {31'h0, ValidD}, e_valid);
        check("instr_d", InstrD, e_instr);
        check("pc4_d", PC4D, e_pc4);
        check("count", {29'h0, Count}, exp_q.size());
        check("stall_f", {31'h0, StallF}, (exp_q.size() == DEPTH) ? 32'h1 : 32'h0);
    endtask

    task automatic model_edge();
        int n;
        bit bypassed;
        n = exp_q.size();
        bypassed = 1'b0;
        if (!reset || FlushD) begin
            exp_q.delete();
            return;
        end
`ifdef IFQ_BYPASS_EN
        if (n == 0 && FetchValid && !StallD) bypassed = 1'b1;
`endif
        if (n > 0 && !StallD) void'(exp_q.pop_front());
        if (FetchValid && n < DEPTH && !bypassed) exp_q.push_back({Instr, PC4});
    endtask

    task automatic cycle(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic sd, input logic fd, input logic rn);
        FetchValid = fv;
        Instr      = ins;
        PC4        = pc;
        StallD     = sd;
        FlushD     = fd;
        reset      = rn;
        @(negedge clk);
        if (chk_en) check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        // Reset: the first edge is unchecked since pre-reset state is unknown.
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Streaming at one word per cycle.
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 32'h20080001 + i, 32'h3004 + 4 * i, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Fill under back-pressure, words 5-6 refused, then drain.
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 32'h10000000 + i, 32'h4000 + 4 * i, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Wrap-around with occupancy held at 3.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h30000000 + i, 32'h3004 + 4 * i, 1'b1, 1'b0, 1'b1);
        for (int i = 3; i < 13; i++)
            cycle(1'b1, 32'h30000000 + i, 32'h3004 + 4 * i, 1'b0, 1'b0, 1'b1);

        // Flush at Count=3 with a word presented; then a fresh push.
        cycle(1'b1, 32'hDEADBEEF, 32'h3FFC, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 32'h00000000, 32'h3100, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset mid-operation at Count=2, then resume.
        cycle(1'b1, 32'h50000001, 32'h5004, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h50000002, 32'h5008, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h50000003, 32'h500C, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h50000004, 32'h5010, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h50000005, 32'h5014, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Empty-queue word with decode ready, then with decode stalled.
        cycle(1'b1, 32'h8C090004, 32'h6004, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h8C090004, 32'h6008, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 49) != 0));
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
